// File: rtl/speed_meter_if.sv
// Signal bundle between a divided-tick source and the speed_meter that decodes it.
// speed_valid qualifies speed_idx; there is no backpressure, and a consumer samples whenever valid is high.
interface speed_meter_if #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
);
    logic             tick_in;
    logic [IDX_W-1:0] speed_idx;
    logic             speed_valid;
    logic             speed_change;
    logic [CNT_W-1:0] period_out;
    logic             stalled;
    logic [1:0]       fsm_state;

    modport master (
        output tick_in,
        input  speed_idx, speed_valid, speed_change, period_out, stalled, fsm_state
    );

    modport slave (
        input  tick_in,
        output speed_idx, speed_valid, speed_change, period_out, stalled, fsm_state
    );
endinterface

// File: rtl/speed_meter.sv
// Decodes a divided tick back into a speed level index by measuring rise-to-rise
// periods, with lock/relock hysteresis and stall detection.
module speed_meter #(
    parameter int BASE_PERIOD = 64,
    parameter int NUM_SPEEDS  = 4,
    parameter int IDX_W       = 2,
    parameter int TOL         = 2,
    parameter int MATCH_N     = 2,
    parameter int TIMEOUT     = 256,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          reset,
    speed_meter_if.slave mif
);
    localparam int MC_W = $clog2(MATCH_N + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             tick_q;
    logic             rise;
    logic             timeout;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [MC_W-1:0]  mc_q, mc_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             change_q, change_d;
    logic             stalled_q, stalled_d;

    assign rise    = mif.tick_in & ~tick_q;
    assign timeout = ~rise && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Scan from the fastest level down so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SPEEDS - 1; i >= 0; i--) begin
            if ((int'(cnt_q) - (BASE_PERIOD >> i) <= TOL) &&
                ((BASE_PERIOD >> i) - int'(cnt_q) <= TOL)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        mc_d      = mc_q;
        cand_d    = cand_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        change_d  = 1'b0;
        stalled_d = stalled_q;

        if (rise)                              cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_W'(TIMEOUT))     cnt_d = cnt_q + 1'b1;

        if (rise) begin
            stalled_d = 1'b0;
            if (state_q == IDLE) begin
                state_d = MEASURE;
            end else begin
                period_d = cnt_q;
                if (!hit) begin
                    mc_d    = '0;
                    valid_d = 1'b0;
                    state_d = MEASURE;
                end else begin
                    if (hit_idx == cand_q) begin
                        if (mc_q < MC_W'(MATCH_N)) mc_d = mc_q + 1'b1;
                    end else begin
                        cand_d = hit_idx;
                        mc_d   = MC_W'(1);
                    end
                    // Old index stays published until the new level is confirmed.
                    if (mc_d == MC_W'(MATCH_N) && (cand_d != idx_q || !valid_q)) begin
                        idx_d    = cand_d;
                        valid_d  = 1'b1;
                        change_d = 1'b1;
                        state_d  = LOCKED;
                    end
                end
            end
        end else if (timeout) begin
            stalled_d = 1'b1;
            valid_d   = 1'b0;
            mc_d      = '0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            mc_q      <= '0;
            cand_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            change_q  <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            tick_q    <= mif.tick_in;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            mc_q      <= mc_d;
            cand_q    <= cand_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            change_q  <= change_d;
            stalled_q <= stalled_d;
        end
    end

    assign mif.speed_idx    = idx_q;
    assign mif.speed_valid  = valid_q;
    assign mif.speed_change = change_q;
    assign mif.period_out   = period_q;
    assign mif.stalled      = stalled_q;
    assign mif.fsm_state    = state_q;
endmodule

// File: tb/tb_speed_meter.sv
// Bench for speed_meter: period-vector table, hand-written stall/reset/corner
// sequences, and random tick periods checked every cycle against a period-level model.
module tb_speed_meter;
    localparam int BASE_PERIOD = 64;
    localparam int NUM_SPEEDS  = 4;
    localparam int IDX_W       = 2;
    localparam int TOL         = 2;
    localparam int MATCH_N     = 2;
    localparam int TIMEOUT     = 256;
    localparam int CNT_W       = 16;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    speed_meter_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) mif ();

    speed_meter #(
        .BASE_PERIOD(BASE_PERIOD), .NUM_SPEEDS(NUM_SPEEDS), .IDX_W(IDX_W), .TOL(TOL),
        .MATCH_N(MATCH_N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    // Field layout in hex: stalled, valid, change, idx, period.
    function automatic logic [63:0] pk(bit st, bit va, bit ch, int idx, int per);
        return (64'(st) << 40) | (64'(va) << 36) | (64'(ch) << 32) | (64'(idx) << 20) | 64'(per);
    endfunction

    function automatic logic [63:0] dut_out();
        return pk(mif.stalled, mif.speed_valid, mif.speed_change,
                  int'(mif.speed_idx), int'(mif.period_out));
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (stalled/valid/change/idx/period)", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on rise timestamps: period = cycles between rises, a level is locked once
    // the tail of the classified-period history holds MATCH_N equal levels.
    int e_idx, e_period;
    bit e_valid, e_change, e_stalled;
    bit have_edge, prev_tick;
    int cnt_ref;
    int hist[$];

    function automatic int classify(int p);
        for (int i = 0; i < NUM_SPEEDS; i++) begin
            int d;
            d = p - (BASE_PERIOD >> i);
            if (d < 0) d = -d;
            if (d <= TOL) return i;
        end
        return -1;
    endfunction

    function automatic int tail_run();
        int n;
        n = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] != hist[hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_step();
        bit rise;
        int p, lvl;
        if (reset) begin
            e_idx = 0; e_period = 0; e_valid = 0; e_change = 0; e_stalled = 0;
            hist.delete(); have_edge = 0; prev_tick = 0; cnt_ref = cyc + 1;
            return;
        end
        rise      = mif.tick_in && !prev_tick;
        prev_tick = mif.tick_in;
        e_change  = 0;
        if (rise) begin
            e_stalled = 0;
            if (have_edge) begin
                p        = cyc - cnt_ref;
                e_period = p;
                lvl      = classify(p);
                if (lvl < 0) begin
                    hist.delete();
                    e_valid = 0;
                end else begin
                    hist.push_back(lvl);
                    if (tail_run() >= MATCH_N && (lvl != e_idx || !e_valid)) begin
                        e_idx = lvl; e_valid = 1; e_change = 1;
                    end
                end
            end
            have_edge = 1;
            cnt_ref   = cyc;
        end else if (cyc - cnt_ref == TIMEOUT - 1) begin
            e_stalled = 1; e_valid = 0; hist.delete(); have_edge = 0;
        end
    endtask

    // ---------------- scoreboard: every cycle against the model ----------------
    always @(posedge clk) begin
        cyc++;
        model_step();
        #2;
        check("cycle_model", dut_out(), pk(e_stalled, e_valid, e_change, e_idx, e_period));
    end

    // ---------------- driver ----------------
    typedef struct {
        int hi;
        int lo;
        int idx;
        bit valid;
        bit change;
        int period;
    } vec_t;

    // Rise now, check the cycle after the rise, then finish the hi/lo waveform.
    task automatic run_vec(string name, vec_t v);
        mif.tick_in = 1'b1;
        for (int j = 0; j < v.hi; j++) begin
            @(negedge clk);
            if (j == 0) check(name, dut_out(), pk(0, v.valid, v.change, v.idx, v.period));
        end
        mif.tick_in = 1'b0;
        repeat (v.lo) @(negedge clk);
    endtask

    vec_t tbl[18];

    initial begin
        #3_000_000;
        bad++;
        $display("FAIL watchdog got=time_expired exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32, 32, 0, 0, 0, 0};
        tbl[1]  = '{32, 32, 0, 0, 0, 64};
        tbl[2]  = '{32, 32, 0, 1, 1, 64};
        tbl[3]  = '{16, 16, 0, 1, 0, 64};
        tbl[4]  = '{16, 16, 0, 1, 0, 32};
        tbl[5]  = '{16, 16, 1, 1, 1, 32};
        tbl[6]  = '{8,  8,  1, 1, 0, 32};
        tbl[7]  = '{8,  8,  1, 1, 0, 16};
        tbl[8]  = '{8,  8,  2, 1, 1, 16};
        tbl[9]  = '{4,  4,  2, 1, 0, 16};
        tbl[10] = '{4,  4,  2, 1, 0, 8};
        tbl[11] = '{4,  4,  3, 1, 1, 8};
        tbl[12] = '{31, 32, 3, 1, 0, 8};
        tbl[13] = '{33, 33, 3, 1, 0, 63};
        tbl[14] = '{24, 24, 0, 1, 1, 66};
        tbl[15] = '{32, 32, 0, 0, 0, 48};
        tbl[16] = '{32, 32, 0, 0, 0, 64};
        tbl[17] = '{32, 32, 0, 1, 1, 64};

        reset       = 1'b1;
        mif.tick_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_out(), pk(0, 0, 0, 0, 0));
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 18; k++) run_vec($sformatf("vec%0d", k), tbl[k]);

        // Stop ticking: stall shows exactly TIMEOUT cycles after the last rise cycle.
        mif.tick_in = 1'b1;
        for (int j = 0; j < TIMEOUT; j++) begin
            @(negedge clk);
            if (j == 31) mif.tick_in = 1'b0;
            if (j == TIMEOUT - 2) check("pre_stall", dut_out(), pk(0, 1, 0, 0, 64));
            if (j == TIMEOUT - 1) check("stall",     dut_out(), pk(1, 0, 0, 0, 64));
        end
        repeat (10) @(negedge clk);

        // Resume, then a period of TIMEOUT-1 where rise and timeout coincide.
        run_vec("resume_first", '{32, 32, 0, 0, 0, 64});
        run_vec("resume_m1",    '{32, 32, 0, 0, 0, 64});
        run_vec("resume_lock",  '{1, 254, 0, 1, 1, 64});
        run_vec("rise_vs_tmo",  '{32, 32, 0, 0, 0, 255});
        run_vec("relock_m1",    '{32, 32, 0, 0, 0, 64});
        run_vec("relock",       '{32, 32, 0, 1, 1, 64});

        // Reset in the middle of a lock.
        reset = 1'b1;
        #1;
        check("async_reset", dut_out(), pk(0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_vec("post_rst_first", '{32, 32, 0, 0, 0, 0});
        run_vec("post_rst_m1",    '{32, 32, 0, 0, 0, 64});
        run_vec("post_rst_lock",  '{32, 32, 0, 1, 1, 64});

        // Random periods: near each level, arbitrary, and around the timeout.
        for (int n = 0; n < 80; n++) begin
            int sel, p, hi;
            sel = $urandom_range(0, 99);
            if (sel < 70)      p = (BASE_PERIOD >> $urandom_range(0, NUM_SPEEDS - 1)) + $urandom_range(0, 6) - 3;
            else if (sel < 85) p = $urandom_range(2, 120);
            else               p = $urandom_range(TIMEOUT - 8, TIMEOUT + 8);
            if (p < 2) p = 2;
            hi = $urandom_range(1, p - 1);
            mif.tick_in = 1'b1;
            repeat (hi) @(negedge clk);
            mif.tick_in = 1'b0;
            repeat (p - hi) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
